xarray_loader: RTL and testbench

XARRAY_LOADER -- requirements
Module: xarray_loader

---
 rtl/xarray_loader_if.sv | 26 ++
 rtl/xarray_loader.sv | 84 ++++++++
 tb/tb_xarray_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/xarray_loader_if.sv
// Handshake bundle between the feature-word source, the xarray loader and the
// inner-product bank that consumes the assembled window.
interface xarray_loader_if #(
  parameter int N = 41,
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic [W-1:0] xarray [0:N-1];
  logic         x_valid;
  logic         x_ack;
  logic         short_frame;
  logic         long_frame;

  modport master (
    output in_valid, in_data, in_last, x_ack,
    input  in_ready, xarray, x_valid, short_frame, long_frame
  );

  modport slave (
    input  in_valid, in_data, in_last, x_ack,
    output in_ready, xarray, x_valid, short_frame, long_frame
  );
endinterface

// File: rtl/xarray_loader.sv
// Collects up to N feature words into a window, presents it to the consumer
// until acknowledged, then clears the window and starts collecting again.
//
//   state | meaning
//   FILL  | accepting words into xarray[cnt]
//   HOLD  | window complete and stable, waiting for x_ack
module xarray_loader #(
  parameter int N = 41,
  parameter int W = 32
) (
  input logic            clock,
  input logic            reset,
  xarray_loader_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   xr [0:N-1];
  logic           accept;
  logic           at_end;
  logic           release_win;
  logic           short_nxt;
  logic           long_nxt;
  logic           short_q;
  logic           long_q;

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    release_win = 1'b0;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;
    at_end      = (cnt == CW'(N - 1));
    case (state)
      FILL: begin
        accept = bus.in_valid;
        if (accept && (bus.in_last || at_end)) begin
          state_nxt = HOLD;
          short_nxt = bus.in_last && !at_end;
          long_nxt  = !bus.in_last && at_end;
        end
      end
      HOLD: begin
        if (bus.x_ack) begin
          release_win = 1'b1;
          state_nxt   = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FILL;
      cnt     <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      for (int i = 0; i < N; i++) xr[i] <= '0;
    end else begin
      state   <= state_nxt;
      short_q <= short_nxt;
      long_q  <= long_nxt;
      if (accept) begin
        xr[cnt] <= bus.in_data;
        // cnt parks at N-1 on a long frame; the ack clears it
        if (!at_end) cnt <= cnt + CW'(1);
      end else if (release_win) begin
        cnt <= '0;
        for (int i = 0; i < N; i++) xr[i] <= '0;
      end
    end
  end

  assign bus.in_ready    = (state == FILL);
  assign bus.x_valid     = (state == HOLD);
  assign bus.short_frame = short_q;
  assign bus.long_frame  = long_q;
  assign bus.xarray      = xr;
endmodule

// File: tb/tb_xarray_loader.sv
// Bench for xarray_loader: queue-based window model checked every cycle, plus
// directed frames (full, short, long, gapped, reset) and randomized frames.
module tb_xarray_loader;
  localparam int N = 41;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  bit   checking = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  xarray_loader_if #(.N(N), .W(W)) bus ();
  xarray_loader #(.N(N), .W(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // model: the words of the current window in arrival order
  logic [W-1:0] frame [$];
  bit m_hold, m_short, m_long;

  function automatic logic [W-1:0] exp_word(int k);
    return (k < frame.size()) ? frame[k] : '0;
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      frame.delete();
      m_hold = 0; m_short = 0; m_long = 0;
    end else begin
      m_short = 0; m_long = 0;
      if (!m_hold) begin
        if (bus.in_valid) begin
          frame.push_back(bus.in_data);
          if (bus.in_last || frame.size() == N) begin
            m_hold  = 1;
            m_short = bus.in_last && (frame.size() < N);
            m_long  = !bus.in_last;
          end
        end
      end else if (bus.x_ack) begin
        m_hold = 0;
        frame.delete();
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      check("in_ready", bus.in_ready, !m_hold);
      check("x_valid", bus.x_valid, m_hold);
      check("short_frame", bus.short_frame, m_short);
      check("long_frame", bus.long_frame, m_long);
      for (int i = 0; i < N; i++)
        check($sformatf("xarray[%0d]", i), bus.xarray[i], exp_word(i));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input bit last, input bit gappy, input bit noise);
    bit acc = 0;
    int tries = 0;
    while (!acc) begin
      if (tries > 200) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: word %0h not accepted, got in_ready %0b expected 1", d, bus.in_ready);
        break;
      end
      tries++;
      bus.x_ack = noise ? 1'($urandom_range(1)) : 1'b0;
      if (gappy && $urandom_range(1) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        tick();
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        acc = bus.in_ready;
        tick();
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.x_ack    = 1'b0;
  endtask

  task automatic ack();
    bus.x_ack = 1'b1;
    tick();
    bus.x_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 32'h1234; bus.in_last = 1'b0; bus.x_ack = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.x_ack = 1'b0;
    tick();
    reset = 1'b0;
    checking = 1'b1;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_x_valid", bus.x_valid, 0);
    check("reset_xarray0", bus.xarray[0], 0);

    // full frame
    for (int k = 0; k < N; k++) send(W'(k + 1), k == N - 1, 0, 0);
    check("full_x_valid", bus.x_valid, 1);
    check("full_in_ready", bus.in_ready, 0);
    check("full_short", bus.short_frame, 0);
    check("full_long", bus.long_frame, 0);
    check("full_x0", bus.xarray[0], 32'd1);
    check("full_x40", bus.xarray[40], 32'd41);
    ack();
    check("ack_in_ready", bus.in_ready, 1);
    check("ack_x0_clear", bus.xarray[0], 0);

    // short frame
    for (int k = 0; k < 5; k++) send(W'(32'hA0 + k), k == 4, 0, 0);
    check("short_pulse", bus.short_frame, 1);
    check("short_x4", bus.xarray[4], 32'hA4);
    check("short_x5", bus.xarray[5], 0);
    tick();
    check("short_pulse_end", bus.short_frame, 0);
    ack();

    // long frame, then in_valid held high during HOLD
    for (int k = 0; k < N; k++) send(W'(32'h100 + k), 0, 0, 0);
    check("long_pulse", bus.long_frame, 1);
    check("long_x_valid", bus.x_valid, 1);
    bus.in_valid = 1'b1; bus.in_data = 32'hDEAD;
    repeat (10) tick();
    check("long_x40_kept", bus.xarray[40], 32'h128);
    check("long_x0_kept", bus.xarray[0], 32'h100);
    bus.x_ack = 1'b1;
    tick();
    bus.x_ack = 1'b0;
    check("turn_in_ready", bus.in_ready, 1);
    check("turn_x_valid", bus.x_valid, 0);
    check("turn_x0", bus.xarray[0], 0);
    bus.in_data = 32'h55; bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("turn_first_word", bus.xarray[0], 32'h55);
    check("turn_short", bus.short_frame, 1);
    ack();

    // gapped full frame with x_ack noise during FILL
    for (int k = 0; k < N; k++) send(W'(k + 1), k == N - 1, 1, 1);
    check("gap_x20", bus.xarray[20], 32'd21);
    ack();

    // reset mid-frame
    for (int k = 0; k < 20; k++) send(W'(32'h300 + k), 0, 0, 0);
    reset = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hBEEF; bus.in_last = 1'b1;
    tick();
    reset = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("rst_mid_x0", bus.xarray[0], 0);
    check("rst_mid_in_ready", bus.in_ready, 1);
    for (int k = 0; k < N; k++) send(W'(32'h400 + k), k == N - 1, 0, 0);
    check("rst_next_x0", bus.xarray[0], 32'h400);
    reset = 1'b1; bus.x_ack = 1'b1;
    tick();
    reset = 1'b0; bus.x_ack = 1'b0;
    check("rst_hold_x_valid", bus.x_valid, 0);
    check("rst_hold_x0", bus.xarray[0], 0);

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(1, N);
      bit lastflag = (len < N) ? 1'b1 : 1'($urandom_range(1));
      bit gappy = 1'($urandom_range(1));
      for (int k = 0; k < len; k++)
        send($urandom, (k == len - 1) && lastflag, gappy, 1);
      repeat ($urandom_range(0, 3)) begin
        bus.in_valid = 1'($urandom_range(1));
        bus.in_data  = $urandom;
        bus.in_last  = 1'($urandom_range(1));
        tick();
      end
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      ack();
    end

    tick();
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
